// File: rtl/uart_pkg.sv
// Shared definitions for the uart transmit/receive glue: arbiter state
// encoding, default sizes and the round-robin search helper.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    localparam int unsigned DEF_DBIT    = 8;
    localparam int unsigned DEF_TIMEOUT = 255;
    localparam int unsigned RR_MAX      = 8;

    // First asserted bit at or above ptr, wrapping at n; one-hot result, zero if none.
    function automatic logic [RR_MAX-1:0] rr_pick(
        input logic [RR_MAX-1:0] req_vec,
        input logic [2:0]        ptr,
        input int unsigned       n
    );
        logic [RR_MAX-1:0] oh;
        int unsigned       idx;
        oh = '0;
        for (int unsigned k = 0; k < RR_MAX; k++) begin
            idx = (32'(ptr) + k) % n;
            if (k < n && oh == '0 && req_vec[3'(idx)]) begin
                oh[3'(idx)] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: request vector plus priority pointer
// to a one-hot grant, its index and a valid flag.
module rr_picker
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);

    logic [RR_MAX-1:0] w_req;
    logic [RR_MAX-1:0] w_pick;

    always_comb begin
        w_req              = '0;
        w_req[N_REQ-1:0]   = req;
    end

    assign w_pick = rr_pick(w_req, 3'(ptr), N_REQ);
    assign grant  = w_pick[N_REQ-1:0];
    assign valid  = |w_pick;

    always_comb begin
        idx = '0;
        for (int unsigned k = 0; k < RR_MAX; k++) begin
            if (w_pick[k]) begin
                idx = PTR_W'(k);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart transmit path between
// N_REQ requesters, with a mid-packet idle timeout and a gap cycle per write.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DBIT    = DEF_DBIT,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned TO_W    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*DBIT-1:0] req_data,
    input  logic [N_REQ-1:0]      req_last,
    output logic [N_REQ-1:0]      req_ack,
    output logic [N_REQ-1:0]      grant,
    input  logic                  tx_ready,
    output logic                  wr_uart,
    output logic [DBIT-1:0]       w_data,
    output logic                  pkt_done,
    output logic                  timeout
);

    localparam int unsigned     PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    arb_state_t       r_state;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] r_gidx;
    logic [TO_W-1:0]  r_cnt;
    logic             r_last;

    logic [N_REQ-1:0] w_pick_grant;
    logic [PTR_W-1:0] w_pick_idx;
    logic             w_pick_valid;
    logic             w_sel_req;
    logic             w_sel_last;
    logic [DBIT-1:0]  w_sel_data;
    logic [PTR_W-1:0] w_next_ptr;

    rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req   (req),
        .ptr   (r_ptr),
        .grant (w_pick_grant),
        .idx   (w_pick_idx),
        .valid (w_pick_valid)
    );

    always_comb begin
        w_sel_req  = 1'b0;
        w_sel_last = 1'b0;
        w_sel_data = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (r_gidx == PTR_W'(k)) begin
                w_sel_req  = req[k];
                w_sel_last = req_last[k];
                w_sel_data = req_data[k*DBIT +: DBIT];
            end
        end
    end

    assign w_next_ptr = (r_gidx == PTR_W'(N_REQ - 1)) ? '0 : r_gidx + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_gidx   <= '0;
            r_cnt    <= '0;
            r_last   <= 1'b0;
            grant    <= '0;
            req_ack  <= '0;
            wr_uart  <= 1'b0;
            w_data   <= '0;
            pkt_done <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            wr_uart  <= 1'b0;
            req_ack  <= '0;
            pkt_done <= 1'b0;
            timeout  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        grant   <= w_pick_grant;
                        r_gidx  <= w_pick_idx;
                        r_cnt   <= '0;
                        r_state <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    // A stalled uart only holds the counter; idleness of the owner is what times out.
                    if (w_sel_req) begin
                        if (tx_ready) begin
                            wr_uart  <= 1'b1;
                            w_data   <= w_sel_data;
                            req_ack  <= grant;
                            r_last   <= w_sel_last;
                            pkt_done <= w_sel_last;
                            r_state  <= ST_GAP;
                        end
                    end else if (r_cnt == TO_LAST) begin
                        timeout <= 1'b1;
                        grant   <= '0;
                        r_ptr   <= w_next_ptr;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_last) begin
                        grant   <= '0;
                        r_ptr   <= w_next_ptr;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= ST_ARM;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester queues, an expected
// write stream and a small uart FIFO model drive a per-cycle output check.
module tb_uart_tx_arbiter;

    localparam int DEPTH = 4;
    localparam int DRAIN = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ack;
    logic [3:0]  grant;
    logic        tx_ready;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic        pkt_done;
    logic        timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ   (4),
        .DBIT    (8),
        .TIMEOUT (255),
        .TO_W    (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .req_ack  (req_ack),
        .grant    (grant),
        .tx_ready (tx_ready),
        .wr_uart  (wr_uart),
        .w_data   (w_data),
        .pkt_done (pkt_done),
        .timeout  (timeout)
    );

    typedef struct packed { logic [7:0] d; logic l; } byte_t;
    typedef struct { int src; logic [7:0] d; logic l; } wr_t;

    byte_t q[4][$];
    wr_t   exp_q[$];
    wr_t   e_cur;
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    to_window = 1'b0;
    bit    fifo_mode = 1'b0;
    int    fifo_cnt = 0;
    int    drain_ctr = 0;
    int    overflows = 0;
    bit    prev_wr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic push_byte(input int src, input logic [7:0] d, input logic l);
        byte_t b;
        wr_t   w;
        b.d = d;
        b.l = l;
        q[src].push_back(b);
        w.src = src;
        w.d   = d;
        w.l   = l;
        exp_q.push_back(w);
    endtask

    task automatic apply_reqs();
        for (int i = 0; i < 4; i++) begin
            if (q[i].size() > 0) begin
                req[i]            = 1'b1;
                req_data[i*8 +: 8] = q[i][0].d;
                req_last[i]       = q[i][0].l;
            end else begin
                req[i]      = 1'b0;
                req_last[i] = 1'b0;
            end
        end
    endtask

    // One cycle: uart FIFO model, then requesters retire acked bytes and present the next.
    task automatic cyc();
        @(negedge clk);
        if (fifo_mode) begin
            if (wr_uart) begin
                if (fifo_cnt >= DEPTH) overflows++;
                else fifo_cnt++;
            end
            drain_ctr++;
            if (drain_ctr >= DRAIN) begin
                drain_ctr = 0;
                if (fifo_cnt > 0) fifo_cnt--;
            end
            tx_ready = (fifo_cnt < DEPTH);
        end
        for (int i = 0; i < 4; i++) begin
            if (req_ack[i] && q[i].size() > 0) void'(q[i].pop_front());
        end
        apply_reqs();
    endtask

    task automatic run_until_drained(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            cyc();
            n++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    always @(posedge clk) begin
        #2;
        check("grant_onehot", 32'($countones(grant) <= 1), 1);
        if (wr_uart) begin
            check("write_gap", prev_wr, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", exp_q.size(), 1);
            end else begin
                e_cur = exp_q.pop_front();
                check("w_data", w_data, e_cur.d);
                check("pkt_done", pkt_done, e_cur.l);
                check("req_ack", req_ack, 1 << e_cur.src);
                check("grant_at_write", grant, 1 << e_cur.src);
            end
        end else begin
            check("req_ack_idle", req_ack, 0);
            check("pkt_done_idle", pkt_done, 0);
        end
        if (!to_window) check("no_timeout", timeout, 0);
        prev_wr = wr_uart;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, n_bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int wr_seen;
        int to_seen;

        reset    = 1'b0;
        req      = '0;
        req_data = '0;
        req_last = '0;
        tx_ready = 1'b1;
        #1;
        check("rst_grant", grant, 0);
        check("rst_ack", req_ack, 0);
        check("rst_wr", wr_uart, 0);
        check("rst_data", w_data, 0);
        check("rst_done", pkt_done, 0);
        check("rst_timeout", timeout, 0);
        repeat (3) cyc();
        reset = 1'b1;
        repeat (2) cyc();

        // Single one-byte packet from requester 0.
        push_byte(0, 8'h41, 1'b1);
        cyc();
        check("t1_grant_before", grant, 4'b0000);
        cyc();
        check("t1_grant", grant, 4'b0001);
        check("t1_wr_early", wr_uart, 0);
        cyc();
        check("t1_wr", wr_uart, 1);
        check("t1_data", w_data, 8'h41);
        check("t1_done", pkt_done, 1);
        check("t1_ack", req_ack, 4'b0001);
        cyc();
        check("t1_grant_clear", grant, 4'b0000);
        check("t1_wr_after", wr_uart, 0);
        check("t1_ack_after", req_ack, 4'b0000);
        repeat (2) cyc();

        // Reset brings the pointer back to 0 before the contention run.
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();

        for (int i = 0; i < 4; i++) begin
            for (int k = 1; k <= 2; k++) push_byte(i, 8'(i*16 + k), (k == 2));
        end
        run_until_drained("t2", 100);
        repeat (3) cyc();

        // Backpressure: requester 1 granted while the uart is full.
        tx_ready = 1'b0;
        push_byte(1, 8'hA5, 1'b1);
        cyc();
        cyc();
        check("t3_grant", grant, 4'b0010);
        wr_seen = 0;
        to_seen = 0;
        repeat (50) begin
            cyc();
            wr_seen += int'(wr_uart);
            to_seen += int'(timeout);
        end
        check("t3_no_write", wr_seen, 0);
        check("t3_no_timeout", to_seen, 0);
        check("t3_grant_held", grant, 4'b0010);
        tx_ready = 1'b1;
        cyc();
        check("t3_wr", wr_uart, 1);
        check("t3_data", w_data, 8'hA5);
        repeat (3) cyc();

        // Timeout: requester 2 stalls mid-packet; 3 must follow before 0.
        to_window = 1'b1;
        push_byte(2, 8'h77, 1'b0);
        push_byte(3, 8'h88, 1'b1);
        push_byte(0, 8'h99, 1'b1);
        cyc();
        n = 0;
        while (!wr_uart && n < 10) begin
            cyc();
            n++;
        end
        check("t4_latency", n, 2);
        check("t4_first_data", w_data, 8'h77);
        n = 0;
        while (!timeout && n < 400) begin
            cyc();
            n++;
        end
        check("t4_timeout_cycle", n, 256);
        check("t4_grant_revoked", grant, 4'b0000);
        cyc();
        check("t4_timeout_pulse", timeout, 0);
        check("t4_next_grant", grant, 4'b1000);
        run_until_drained("t4", 40);
        repeat (3) cyc();
        to_window = 1'b0;

        // Asynchronous reset in the middle of a write.
        push_byte(1, 8'h55, 1'b0);
        push_byte(1, 8'h56, 1'b1);
        cyc();
        n = 0;
        while (!wr_uart && n < 10) begin
            cyc();
            n++;
        end
        check("t5_wr", wr_uart, 1);
        check("t5_data", w_data, 8'h55);
        reset = 1'b0;
        #1;
        check("t5_rst_wr", wr_uart, 0);
        check("t5_rst_grant", grant, 0);
        check("t5_rst_ack", req_ack, 0);
        check("t5_rst_done", pkt_done, 0);
        check("t5_rst_timeout", timeout, 0);
        check("t5_rst_data", w_data, 0);
        q[1].delete();
        exp_q.delete();
        apply_reqs();
        cyc();
        cyc();
        reset = 1'b1;
        push_byte(3, 8'hC3, 1'b1);
        cyc();
        cyc();
        check("t5_grant_after_reset", grant, 4'b1000);
        cyc();
        check("t5_wr_after_reset", wr_uart, 1);
        check("t5_data_after_reset", w_data, 8'hC3);
        repeat (3) cyc();

        // Slow uart FIFO: three 50-byte packets, pointer wrapped to 0.
        fifo_mode = 1'b1;
        fifo_cnt  = 0;
        drain_ctr = 0;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 50; k++) push_byte(i, 8'(i*64 + k), (k == 49));
        end
        run_until_drained("t6", 8000);
        check("t6_no_overflow", overflows, 0);
        check("t6_queues_empty", q[0].size() + q[1].size() + q[2].size(), 0);
        fifo_mode = 1'b0;
        tx_ready  = 1'b1;
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single transmit path of one `uart` instance between N_REQ requesters, e.g. a command formatter, a debug dump and a status reporter.
- Arbitration is packet-granular and round-robin. A requester keeps the grant until it flags its last byte, or until it goes idle for longer than TIMEOUT cycles.
- Drives the uart's `wr_uart`/`w_data`, gated by the uart's `tx_ready`. Always inserts one gap cycle after every write.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DBIT, 8, data width; matches the uart DBIT.
- TIMEOUT, 255, maximum idle cycles tolerated mid-packet before the grant is revoked.
- TO_W, 8, timeout counter width; TIMEOUT must fit in TO_W bits.

Ports:
- clk  input  1  system clock.
- reset  input  1  reset, asynchronous, active-low.
- req  input  N_REQ  per-requester byte-valid.
- req_data  input  N_REQ*DBIT  flattened byte buses; requester i occupies [i*DBIT +: DBIT].
- req_last  input  N_REQ  qualifies req_data as the final byte of the packet.
- req_ack  output  N_REQ  one-hot, one-cycle pulse: byte of requester i accepted.
- grant  output  N_REQ  one-hot current owner; all zero when idle.
- tx_ready  input  1  from uart; FIFO can accept a byte.
- wr_uart  output  1  one-cycle write strobe to uart.
- w_data  output  DBIT  byte to uart; valid while wr_uart=1.
- pkt_done  output  1  one-cycle pulse when the last byte of a packet is written.
- timeout  output  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; grant, req_ack, wr_uart, w_data, pkt_done, timeout all 0.
  - Round-robin pointer=0, so requester 0 has highest priority first.
  - Reset mid-write truncates any pulse; no partial state survives.
- All outputs are registered.
- States: IDLE, ARM, GAP.
- IDLE:
  - If any req bit is 1, pick the first asserted index searching upward from ptr with wrap (ptr, ptr+1, ... N_REQ-1, 0, ...).
  - Set grant one-hot to that index, clear the timeout counter, go to ARM.
  - If no req, stay in IDLE.
- ARM (grant held on index g):
  - If req[g]=1 and tx_ready=1:
    - next cycle drives wr_uart=1, w_data=req_data[g], req_ack[g]=1;
    - latch last=req_last[g];
    - go to GAP.
  - If req[g]=1 and tx_ready=0: wait. The counter does not count; a full uart FIFO never causes a timeout.
  - If req[g]=0: increment the counter.
    - When the counter reaches TIMEOUT: pulse timeout, clear grant, set ptr=g+1 mod N_REQ, go to IDLE.
- GAP:
  - wr_uart/req_ack are high during this cycle; one cycle only. This allows for the uart's registered full flag.
  - If last=1: pulse pkt_done coincident with wr_uart, clear grant at the next edge, set ptr=g+1 mod N_REQ, go to IDLE.
  - Otherwise go to ARM and clear the counter.
- Latency:
  - req rises before edge k in IDLE → grant from k.
  - First wr_uart in the cycle after edge k+1, if tx_ready=1.
  - Peak throughput is 1 byte per 2 cycles.
- Requester contract:
  - Hold req/req_data/req_last stable until req_ack is seen.
  - It may present the next byte on the edge that ends req_ack.
- A single-byte packet is req_last=1 on the first byte.
- Requests from non-granted requesters are ignored; they are never acked and never lost, and remain pending.
- Simultaneous events:
  - A requester dropping req in the same cycle ARM would accept is not accepted.
  - req_last on a byte that is being timed out cannot happen, because timeout requires req=0.
- Pointer wrap: ptr=N_REQ-1 advances to 0.
- w_data holds its last value when wr_uart=0.

Decomposition:
- Shared package `uart_pkg`:
  - state encoding constants (IDLE/ARM/GAP);
  - default DBIT and the TIMEOUT constant;
  - the round-robin search function, also reusable by the rx dispatcher.
- One natural sub-module: `rr_picker`. It is combinational: req vector + ptr → one-hot grant and valid. It is instantiated once and unit-testable alone.
- The timeout counter and FSM stay in the top module.

Test Plan:
- Reset then single request: req=4'b0001, data 8'h41, last=1, tx_ready=1 → grant=0001 next edge; wr_uart with w_data=41 one cycle later; pkt_done coincident; grant=0 after; req_ack[0] exactly one pulse.
- Contention/round-robin:
  - req=4'b1111, each sends a 2-byte packet (i*16+1, i*16+2) → uart sees 01,02,11,12,21,22,31,32 in order;
  - no interleaving within packets;
  - every wr_uart followed by ≥1 idle cycle.
- Backpressure: tx_ready=0 for 50 cycles while granted with req=1 → no wr_uart, no timeout; tx_ready=1 → byte written next cycle.
- Timeout:
  - TIMEOUT=255; requester 2 sends 1 non-last byte then drops req → timeout pulse exactly 255 cycles after it entered ARM with req=0, grant cleared;
  - pending requester 3 is granted next, before requester 0.
- Async reset mid-packet: assert reset while wr_uart=1 → all outputs 0 immediately; after release with req=4'b1000, ptr=0 search still grants requester 3; data intact.
- Loopback with a uart pair (8N1, dvsr=6, os_tick=72): 3 requesters × 50-byte packets → the receiving uart reads all 150 bytes, packet-contiguous, and no e_txof.
